// File: rtl/ofm_reader_pkg.sv
// Shared constants, state encoding and helpers for the OFM stream reader.
package ofm_reader_pkg;

  localparam int ELEMS      = 128 / 16;
  localparam int NUM_WORDS  = (4096 + ELEMS - 1) / ELEMS;
  localparam int SIZE_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Elements fetched by one read: a full word, or whatever is left at the tail.
  function automatic logic [SIZE_WIDTH-1:0] read_size(input int unsigned remaining,
                                                      input int unsigned lanes);
    if (remaining >= lanes) return SIZE_WIDTH'(lanes);
    return SIZE_WIDTH'(remaining);
  endfunction

endpackage

// File: rtl/ofm_skid_fifo.sv
// Two-entry FIFO that absorbs the DPRAM read latency and downstream stalls.
module ofm_skid_fifo #(
  parameter int WIDTH = 134
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage, pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

  // The upstream credit rule must keep pushes away from a full FIFO.
  push_not_full: assert property (@(posedge clk) disable iff (rst) !(push && count == 2'd2));
  pop_not_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == 2'd0));

endmodule

// File: rtl/ofm_stream_reader.sv
// Sequential OFM DPRAM port-A reader streaming 128-bit words over valid/ready.
//
// state | meaning
// IDLE  | waiting for start, no reads, no stream activity
// READ  | issuing reads whenever the credit rule allows
// DRAIN | last read issued; waiting for the last word to be accepted
module ofm_stream_reader
  import ofm_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int INOUT_WIDTH   = 128,
  parameter int OFM_ADDR_LINE = 4096,
  parameter int ADDR_WIDTH    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   ofm_re,
  output logic [ADDR_WIDTH-1:0]  ofm_addr,
  output logic [SIZE_WIDTH-1:0]  ofm_size,
  input  logic [INOUT_WIDTH-1:0] ofm_rdata,
  output logic [INOUT_WIDTH-1:0] m_data,
  output logic [SIZE_WIDTH-1:0]  m_size,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done
);

  localparam int LANES  = INOUT_WIDTH / DATA_WIDTH;
  localparam int FIFO_W = INOUT_WIDTH + SIZE_WIDTH + 1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    inflight;
  logic [SIZE_WIDTH-1:0]   cap_size;
  logic                    cap_last;

  logic [ADDR_WIDTH:0]     remaining;
  logic [SIZE_WIDTH-1:0]   issue_size;
  logic                    issue_last;
  logic                    issue;
  logic                    pop;
  logic [2:0]              occupancy;

  logic [1:0]              fifo_count;
  logic [FIFO_W-1:0]       fifo_din;
  logic [FIFO_W-1:0]       fifo_dout;
  logic [INOUT_WIDTH-1:0]  head_data;
  logic [SIZE_WIDTH-1:0]   head_size;
  logic                    head_last;

  // Size of the next read and whether it reaches the end of the map.
  always_comb begin
    remaining  = (ADDR_WIDTH + 1)'(OFM_ADDR_LINE) - {1'b0, addr};
    issue_size = read_size(32'(remaining), LANES);
    issue_last = ((ADDR_WIDTH + 1)'(issue_size) == remaining);
  end

  assign m_valid   = (fifo_count != 2'd0);
  assign pop       = m_valid & m_ready;

  // Words held or on their way must stay below two, counting this cycle's pop.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    issue     = (state == READ) && ((occupancy - {2'b00, pop}) < 3'd2);
  end

  assign ofm_re   = issue;
  assign ofm_addr = issue ? addr : '0;
  assign ofm_size = issue ? issue_size : '0;
  assign busy     = (state == READ) || (state == DRAIN);

  // Controller: state, read address, capture tags and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      inflight <= 1'b0;
      cap_size <= '0;
      cap_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        cap_size <= issue_size;
        cap_last <= issue_last;
        addr     <= issue_last ? '0 : addr + ADDR_WIDTH'(issue_size);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            addr  <= '0;
          end
        end
        READ: begin
          if (issue && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && head_last && fifo_count == 2'd1 && !inflight) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_din = {ofm_rdata, cap_size, cap_last};

  ofm_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .count(fifo_count)
  );

  assign head_data = fifo_dout[FIFO_W-1 -: INOUT_WIDTH];
  assign head_size = fifo_dout[SIZE_WIDTH:1];
  assign head_last = fifo_dout[0];

  // Present the FIFO head, zeroing lanes beyond the valid element count.
  always_comb begin
    m_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (m_valid && (SIZE_WIDTH'(k) < head_size))
        m_data[k*DATA_WIDTH +: DATA_WIDTH] = head_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    m_size = m_valid ? head_size : '0;
    m_last = m_valid & head_last;
  end

endmodule

// File: tb/tb_ofm_stream_reader.sv
// Directed bench for ofm_stream_reader: full map and 20-element map instances.
module tb_ofm_stream_reader;

  logic         clk;
  logic         rst;
  logic         start;
  logic         ofm_re;
  logic [11:0]  ofm_addr;
  logic [4:0]   ofm_size;
  logic [127:0] ofm_rdata;
  logic [127:0] m_data;
  logic [4:0]   m_size;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         busy;
  logic         done;

  logic         s_start;
  logic         s_re;
  logic [4:0]   s_addr;
  logic [4:0]   s_size;
  logic [127:0] s_rdata;
  logic [127:0] s_data;
  logic [4:0]   s_msize;
  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  logic         s_busy;
  logic         s_done;

  int vectors;
  int miscompares;

  ofm_stream_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .ofm_re(ofm_re), .ofm_addr(ofm_addr), .ofm_size(ofm_size), .ofm_rdata(ofm_rdata),
    .m_data(m_data), .m_size(m_size), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done)
  );

  ofm_stream_reader #(
    .DATA_WIDTH(16), .INOUT_WIDTH(128), .OFM_ADDR_LINE(20), .ADDR_WIDTH(5)
  ) dut_s (
    .clk(clk), .rst(rst), .start(s_start),
    .ofm_re(s_re), .ofm_addr(s_addr), .ofm_size(s_size), .ofm_rdata(s_rdata),
    .m_data(s_data), .m_size(s_msize), .m_valid(s_valid), .m_ready(s_ready),
    .m_last(s_last), .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DPRAM models: element i holds i; the small map returns junk past its end.
  always @(posedge clk) begin
    if (ofm_re)
      for (int k = 0; k < 8; k++) ofm_rdata[k*16 +: 16] <= 16'(int'(ofm_addr) + k);
    if (s_re)
      for (int k = 0; k < 8; k++)
        s_rdata[k*16 +: 16] <= (int'(s_addr) + k < 20) ? 16'(int'(s_addr) + k) : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] word_of(input int base, input int n);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*16 +: 16] = 16'(base + k);
    return w;
  endfunction

  // One readout on the full-size instance. ready_mode 0: always ready;
  // 1: ~30% ready plus a 20-cycle stall at word 300. restart_at / rst_at are
  // word indices for a second start pulse / a reset injection (-1 = none).
  task automatic run_default(input int ready_mode, input int restart_at, input int rst_at,
                             output int n_words, output int n_done, output int first_valid,
                             output int last_hs, output int done_cyc);
    int           cyc, tb_cnt, tb_infl, exp_addr, stall_left;
    bit           stall_used, restarted, prev_stall, popped;
    logic [127:0] prev_data;
    logic         prev_last;
    n_words = 0; n_done = 0; first_valid = -1; last_hs = -1; done_cyc = -1;
    tb_cnt = 0; tb_infl = 0; exp_addr = 0; stall_left = 0;
    stall_used = 0; restarted = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    forever begin
      start = 1'b0;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("done_single_cycle", 128'(done), 128'(0));
        chk("idle_after_done", 128'(busy), 128'(0));
        break;
      end
      if (cyc > 5000) begin
        chk("run_timeout", 128'(0), 128'(1));
        break;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      chk("valid_vs_model", 128'(m_valid), 128'(tb_cnt != 0));
      if (prev_stall) begin
        chk("stall_valid", 128'(m_valid), 128'(1));
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 128'(m_last), 128'(prev_last));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (rst_at >= 0 && n_words == rst_at) begin
        m_ready = 1'b0;
        #2;
        chk("pre_rst_valid", 128'(m_valid), 128'(1));
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 128'(m_valid), 128'(0));
        chk("rst_async_busy", 128'(busy), 128'(0));
        chk("rst_async_re", 128'(ofm_re), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_flushed", 128'(m_valid), 128'(0));
        break;
      end
      if (ready_mode == 0) begin
        m_ready = 1'b1;
      end else if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (n_words == 300 && !stall_used) begin
        m_ready = 1'b0;
        stall_used = 1;
        stall_left = 19;
      end else begin
        m_ready = ($urandom_range(0, 99) < 30);
      end
      if (restart_at >= 0 && n_words == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      #1;
      popped = m_valid && m_ready;
      if (ofm_re) begin
        chk("credit_rule", 128'((tb_cnt + tb_infl - int'(popped)) < 2), 128'(1));
        chk("ofm_addr", 128'(ofm_addr), 128'(exp_addr));
        chk("ofm_size", 128'(ofm_size), 128'(8));
        exp_addr += 8;
      end
      if (popped) begin
        chk("word_data", m_data, word_of(8 * n_words, 8));
        chk("word_size", 128'(m_size), 128'(8));
        chk("word_last", 128'(m_last), 128'(n_words == 511));
        if (n_words == 511) last_hs = cyc;
        n_words++;
      end
      tb_cnt     = tb_cnt + tb_infl - int'(popped);
      tb_infl    = int'(ofm_re);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int nw, nd, fv, lh, dc;
    int iss_size[$], iss_addr[$], rx_size[$], rx_last[$];
    logic [127:0] rx_data[$];
    int s_done_cnt;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_valid", 128'(m_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_ofm_re", 128'(ofm_re), 128'(0));
    chk("reset_ofm_addr", 128'(ofm_addr), 128'(0));
    chk("reset_ofm_size", 128'(ofm_size), 128'(0));
    chk("reset_m_data", m_data, 128'(0));
    chk("reset_m_size", 128'(m_size), 128'(0));
    chk("reset_m_last", 128'(m_last), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ignores_nothing", 128'(busy), 128'(0));

    // Full-rate readout.
    run_default(0, -1, -1, nw, nd, fv, lh, dc);
    chk("full_words", 128'(nw), 128'(512));
    chk("full_done_count", 128'(nd), 128'(1));
    chk("full_first_valid", 128'(fv), 128'(2));
    chk("full_last_handshake", 128'(lh), 128'(513));
    chk("full_done_cycle", 128'(dc), 128'(514));

    // Back-to-back: start in the cycle right after done.
    run_default(0, -1, -1, nw, nd, fv, lh, dc);
    chk("b2b_words", 128'(nw), 128'(512));
    chk("b2b_done_count", 128'(nd), 128'(1));
    chk("b2b_first_valid", 128'(fv), 128'(2));
    chk("b2b_last_handshake", 128'(lh), 128'(513));
    chk("b2b_done_cycle", 128'(dc), 128'(514));

    // Backpressure.
    run_default(1, -1, -1, nw, nd, fv, lh, dc);
    chk("bp_words", 128'(nw), 128'(512));
    chk("bp_done_count", 128'(nd), 128'(1));
    chk("bp_done_after_last", 128'(dc - lh), 128'(1));

    // Second start while busy.
    run_default(0, 100, -1, nw, nd, fv, lh, dc);
    chk("restart_words", 128'(nw), 128'(512));
    chk("restart_done_count", 128'(nd), 128'(1));
    chk("restart_done_cycle", 128'(dc), 128'(514));

    // Reset mid-stream, then a clean full readout.
    run_default(0, -1, 200, nw, nd, fv, lh, dc);
    chk("rst_words_before", 128'(nw), 128'(200));
    chk("rst_no_done", 128'(nd), 128'(0));
    run_default(0, -1, -1, nw, nd, fv, lh, dc);
    chk("post_rst_words", 128'(nw), 128'(512));
    chk("post_rst_done_count", 128'(nd), 128'(1));
    chk("post_rst_first_valid", 128'(fv), 128'(2));

    // Partial final word on the 20-element instance.
    s_done_cnt = 0;
    s_ready = 1'b1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (s_done) s_done_cnt++;
      if (s_re) begin
        iss_size.push_back(int'(s_size));
        iss_addr.push_back(int'(s_addr));
      end
      if (s_valid && s_ready) begin
        rx_size.push_back(int'(s_msize));
        rx_last.push_back(int'(s_last));
        rx_data.push_back(s_data);
      end
      @(posedge clk); #1;
    end
    chk("small_issue_count", 128'(iss_size.size()), 128'(3));
    chk("small_word_count", 128'(rx_size.size()), 128'(3));
    chk("small_done_count", 128'(s_done_cnt), 128'(1));
    for (int i = 0; i < 3; i++) begin
      int exp_sz;
      exp_sz = (i == 2) ? 4 : 8;
      chk("small_ofm_size", 128'((i < iss_size.size()) ? iss_size[i] : -1), 128'(exp_sz));
      chk("small_ofm_addr", 128'((i < iss_addr.size()) ? iss_addr[i] : -1), 128'(8 * i));
      chk("small_m_size", 128'((i < rx_size.size()) ? rx_size[i] : -1), 128'(exp_sz));
      chk("small_m_last", 128'((i < rx_last.size()) ? rx_last[i] : -1), 128'(i == 2));
      chk("small_m_data", (i < rx_data.size()) ? rx_data[i] : {128{1'b1}}, word_of(8 * i, exp_sz));
    end
    chk("small_last_word_literal", (rx_data.size() > 2) ? rx_data[2] : {128{1'b1}},
        128'h0000_0000_0000_0000_0013_0012_0011_0010);
    chk("small_idle_after", 128'(s_busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
